vga_timing_gen: RTL and testbench

Raster timing generator for the 640x480 VGA display path: free-running horizontal/vertical counters on the pixel clock produce the DrawX/DrawY/blank bus consumed by every sprite/ROM/palette drawing block, plus the monitor sync pulses. The sync outputs have a fixed, parameterised delay so they stay aligned with the RGB pipeline of the drawing blocks (synchronous ROM read plus registered colour output). It sits between the pixel-clock PLL and the sprite/compositor blocks and feeds hs/vs to the VGA connector.

---
 rtl/vga_timing_gen.sv | 148 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for the 640x480 VGA display path. Free-running
// horizontal/vertical counters on the pixel clock provide the DrawX/DrawY/
// blank bus used by the sprite, ROM and palette drawing blocks. The monitor
// sync pulses are delayed by SYNC_DELAY cycles so they line up with the RGB
// pipeline of those blocks (synchronous ROM read plus registered colour).
//
// Ports:
//   vga_clk     in   pixel clock, all state changes on its rising edge
//   reset_n     in   asynchronous, active-low reset
//   DrawX       out  [9:0] horizontal count, 0..H_TOTAL-1
//   DrawY       out  [9:0] vertical count, 0..V_TOTAL-1
//   blank       out  1 = active video, 0 = blanking
//   hs          out  horizontal sync, active-low, delayed SYNC_DELAY cycles
//   vs          out  vertical sync, active-low, delayed SYNC_DELAY cycles
//   line_start  out  high while DrawX == 0
//   frame_start out  high while DrawX == 0 and DrawY == 0
//   frame_cnt   out  [15:0] completed-frame count (VGA_FRAME_CNT_EN only)
//
// Build option:
//   VGA_FRAME_CNT_EN  when defined, adds the frame_cnt port and its 16-bit
//                     register; all other behaviour is unchanged.
//
// Parameter limits: H_TOTAL and V_TOTAL must each be <= 1024 so the counts
// fit the fixed 10-bit counters; SYNC_DELAY is legal from 0 to 4.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Region bounds are held at 11 bits: a sync window ending exactly at
  // 1024 would otherwise alias to 0 in a 10-bit compare.
  localparam logic [10:0] H_ACT_END    = 11'(H_VISIBLE);
  localparam logic [10:0] V_ACT_END    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START     = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END       = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START     = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END       = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic        line_end;
  logic        frame_end;
  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic        hs_raw;
  logic        vs_raw;

  assign line_end  = (DrawX == H_LAST);
  assign frame_end = line_end && (DrawY == V_LAST);

  // Raster counters. DrawX/DrawY are the registers themselves so every
  // downstream block sees the position with no extra decode latency.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX <= '0;
      DrawY <= '0;
    end else if (line_end) begin
      DrawX <= '0;
      if (DrawY == V_LAST) begin
        DrawY <= '0;
      end else begin
        DrawY <= DrawY + 10'd1;
      end
    end else begin
      DrawX <= DrawX + 10'd1;
    end
  end

  // Zero-latency decodes of the current counter state.
  assign x_ext       = {1'b0, DrawX};
  assign y_ext       = {1'b0, DrawY};
  assign blank       = (x_ext < H_ACT_END) && (y_ext < V_ACT_END);
  assign line_start  = (DrawX == 10'd0);
  assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign hs_raw      = !((x_ext >= HS_START) && (x_ext < HS_END));
  assign vs_raw      = !((y_ext >= VS_START) && (y_ext < VS_END));

  // Sync alignment. Each stage resets to the inactive level so the pipe
  // cannot emit a spurious pulse while it fills after reset.
  generate
    if (SYNC_DELAY == 0) begin : g_sync_direct
      assign hs = hs_raw;
      assign vs = vs_raw;
    end else begin : g_sync_delay
      logic [SYNC_DELAY-1:0] hs_pipe;
      logic [SYNC_DELAY-1:0] vs_pipe;

      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          hs_pipe <= '1;
          vs_pipe <= '1;
        end else begin
          hs_pipe[0] <= hs_raw;
          vs_pipe[0] <= vs_raw;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
          end
        end
      end

      assign hs = hs_pipe[SYNC_DELAY-1];
      assign vs = vs_pipe[SYNC_DELAY-1];
    end
  endgenerate

`ifdef VGA_FRAME_CNT_EN
  // Completed-frame counter: steps on the same edge that wraps the raster
  // to (0,0), so it changes in the cycle frame_start rises. Wraps freely.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Self-checking bench for vga_timing_gen. Three instances share clock and
// reset: the default 640x480 geometry, a reduced geometry with the default
// sync delay (so whole frames fit in a short run), and the reduced geometry
// with SYNC_DELAY = 0. A reference model computes every output from the
// number of rising edges since reset release using plain arithmetic; a
// negedge process compares all instances against it, and edge watchers pin
// the sync placement, pulse widths and frame wrap to literal values.
// Resets are applied at random points within the clock period.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  // Reduced geometry: 80 x 55 = 4400 cycles per frame.
  localparam int S_HV = 64;
  localparam int S_HF = 4;
  localparam int S_HS = 8;
  localparam int S_HB = 4;
  localparam int S_VV = 48;
  localparam int S_VF = 2;
  localparam int S_VS = 2;
  localparam int S_VB = 3;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  logic [9:0] dx_d, dy_d, dx_s, dy_s, dx_z, dy_z;
  logic       bl_d, hs_d, vs_d, ls_d, fs_d;
  logic       bl_s, hs_s, vs_s, ls_s, fs_s;
  logic       bl_z, hs_z, vs_z, ls_z, fs_z;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc_d, fc_s, fc_z;
  logic [15:0] prev_fc_s;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int n_cyc        = 0;
  bit cmp_on       = 1'b0;

  // Watcher state for the literal placement checks.
  bit   armed          = 1'b0;
  logic prev_hs_d      = 1'b1;
  int   hs_low_d       = 0;
  bit   hs_fall_seen_d = 1'b0;
  logic prev_vs_s      = 1'b1;
  int   vs_low_s       = 0;
  bit   vs_fall_seen_s = 1'b0;
  int   last_vs_fall_n = -1;
  logic [9:0] prev_x_s = '0;
  logic [9:0] prev_y_s = '0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (dx_d),
    .DrawY       (dy_d),
    .blank       (bl_d),
    .hs          (hs_d),
    .vs          (vs_d),
    .line_start  (ls_d),
    .frame_start (fs_d)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (fc_d)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .SYNC_DELAY(2)
  ) dut_s (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (dx_s),
    .DrawY       (dy_s),
    .blank       (bl_s),
    .hs          (hs_s),
    .vs          (vs_s),
    .line_start  (ls_s),
    .frame_start (fs_s)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (fc_s)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .SYNC_DELAY(0)
  ) dut_z (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (dx_z),
    .DrawY       (dy_z),
    .blank       (bl_z),
    .hs          (hs_z),
    .vs          (vs_z),
    .line_start  (ls_z),
    .frame_start (fs_z)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (fc_z)
`endif
  );

  // Rising edges since the last reset release: the model's only state.
  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) n_cyc <= 0;
    else          n_cyc <= n_cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit inWindow(input int v, input int lo, input int len);
    return (v >= lo) && (v < lo + len);
  endfunction

  // Expected outputs after n edges: position is n folded into the raster,
  // sync is the raw window test evaluated d edges earlier (inactive before
  // that many edges have elapsed since reset).
  task automatic checkModel(input string tag, input int n,
                            input int hv, input int hf, input int hsw, input int hb,
                            input int vv, input int vf, input int vsw, input int vb,
                            input int d,
                            input logic [9:0] x, input logic [9:0] y,
                            input logic bl, input logic h, input logic v,
                            input logic ls, input logic fs);
    int   ht, vt, px, py, m;
    logic e_h, e_v;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    px = n % ht;
    py = (n / ht) % vt;
    if (n < d) begin
      e_h = 1'b1;
      e_v = 1'b1;
    end else begin
      m   = n - d;
      e_h = !inWindow(m % ht, hv + hf, hsw);
      e_v = !inWindow((m / ht) % vt, vv + vf, vsw);
    end
    checkOutput({tag, ".DrawX"},       32'(x),  32'(px));
    checkOutput({tag, ".DrawY"},       32'(y),  32'(py));
    checkOutput({tag, ".blank"},       32'(bl), 32'((px < hv) && (py < vv)));
    checkOutput({tag, ".hs"},          32'(h),  32'(e_h));
    checkOutput({tag, ".vs"},          32'(v),  32'(e_v));
    checkOutput({tag, ".line_start"},  32'(ls), 32'(px == 0));
    checkOutput({tag, ".frame_start"}, 32'(fs), 32'((px == 0) && (py == 0)));
  endtask

  // Per-cycle comparison against the model plus literal edge watchers.
  always @(negedge vga_clk) begin
    if (cmp_on) begin
      checkModel("def",  n_cyc, 640, 16, 96, 48, 480, 10, 2, 33, 2,
                 dx_d, dy_d, bl_d, hs_d, vs_d, ls_d, fs_d);
      checkModel("sml",  n_cyc, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 2,
                 dx_s, dy_s, bl_s, hs_s, vs_s, ls_s, fs_s);
      checkModel("sml0", n_cyc, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 0,
                 dx_z, dy_z, bl_z, hs_z, vs_z, ls_z, fs_z);
`ifdef VGA_FRAME_CNT_EN
      checkOutput("def.frame_cnt",  32'(fc_d), 32'((n_cyc / 420000) % 65536));
      checkOutput("sml.frame_cnt",  32'(fc_s), 32'((n_cyc / 4400) % 65536));
      checkOutput("sml0.frame_cnt", 32'(fc_z), 32'((n_cyc / 4400) % 65536));
`endif

      if (!reset_n) begin
        armed          <= 1'b0;
        hs_fall_seen_d <= 1'b0;
        vs_fall_seen_s <= 1'b0;
        last_vs_fall_n <= -1;
      end else begin
        armed <= 1'b1;
        if (armed) begin
          if (prev_hs_d && !hs_d) begin
            checkOutput("def.hs_fall_x", 32'(dx_d), 32'd658);
            hs_fall_seen_d <= 1'b1;
            hs_low_d       <= 1;
          end else if (!prev_hs_d && !hs_d) begin
            hs_low_d <= hs_low_d + 1;
          end else if (!prev_hs_d && hs_d && hs_fall_seen_d) begin
            checkOutput("def.hs_low_len", 32'(hs_low_d), 32'd96);
            checkOutput("def.hs_rise_x",  32'(dx_d),     32'd754);
          end

          if (prev_vs_s && !vs_s) begin
            checkOutput("sml.vs_fall_x", 32'(dx_s), 32'd2);
            checkOutput("sml.vs_fall_y", 32'(dy_s), 32'd50);
            if (last_vs_fall_n >= 0)
              checkOutput("sml.vs_period", 32'(n_cyc - last_vs_fall_n), 32'd4400);
            last_vs_fall_n <= n_cyc;
            vs_fall_seen_s <= 1'b1;
            vs_low_s       <= 1;
          end else if (!prev_vs_s && !vs_s) begin
            vs_low_s <= vs_low_s + 1;
          end else if (!prev_vs_s && vs_s && vs_fall_seen_s) begin
            checkOutput("sml.vs_low_len", 32'(vs_low_s), 32'd160);
          end

          if ((prev_x_s == 10'd79) && (prev_y_s == 10'd54)) begin
            checkOutput("sml.wrap_x",  32'(dx_s), 32'd0);
            checkOutput("sml.wrap_y",  32'(dy_s), 32'd0);
            checkOutput("sml.wrap_fs", 32'(fs_s), 32'd1);
            checkOutput("sml.wrap_ls", 32'(ls_s), 32'd1);
`ifdef VGA_FRAME_CNT_EN
            checkOutput("sml.wrap_fc", 32'(fc_s), 32'(16'(prev_fc_s + 16'd1)));
`endif
          end
        end
      end
      prev_hs_d <= hs_d;
      prev_vs_s <= vs_s;
      prev_x_s  <= dx_s;
      prev_y_s  <= dy_s;
`ifdef VGA_FRAME_CNT_EN
      prev_fc_s <= fc_s;
`endif
    end
  end

  // Reset pulse asserted assert_off after a rising edge, held for hold
  // edges, released release_off after the last of them. Offsets avoid the
  // clock edges. Reset values must appear without waiting for a clock.
  task automatic applyStimulus(input int assert_off, input int hold, input int release_off);
    @(posedge vga_clk);
    #(assert_off) reset_n = 1'b0;
    #1;
    checkOutput("async.def_x",  32'(dx_d), 32'd0);
    checkOutput("async.def_y",  32'(dy_d), 32'd0);
    checkOutput("async.def_hs", 32'(hs_d), 32'd1);
    checkOutput("async.def_vs", 32'(vs_d), 32'd1);
    checkOutput("async.sml_x",  32'(dx_s), 32'd0);
    checkOutput("async.sml_y",  32'(dy_s), 32'd0);
    checkOutput("async.sml_vs", 32'(vs_s), 32'd1);
    checkOutput("async.sml_fs", 32'(fs_s), 32'd1);
`ifdef VGA_FRAME_CNT_EN
    checkOutput("async.sml_fc", 32'(fc_s), 32'd0);
`endif
    repeat (hold) @(posedge vga_clk);
    #(release_off) reset_n = 1'b1;
  endtask

  function automatic int offClockEdge();
    int p;
    p = $urandom_range(1, 8);
    if (p >= 5) p++;
    return p;
  endfunction

  initial begin
    bit found;

    reset_n = 1'b0;
    @(posedge vga_clk);
    #1 cmp_on = 1'b1;
    repeat (2) @(posedge vga_clk);
    #1;
    checkOutput("rst.DrawX",       32'(dx_d), 32'd0);
    checkOutput("rst.DrawY",       32'(dy_d), 32'd0);
    checkOutput("rst.blank",       32'(bl_d), 32'd1);
    checkOutput("rst.hs",          32'(hs_d), 32'd1);
    checkOutput("rst.vs",          32'(vs_d), 32'd1);
    checkOutput("rst.frame_start", 32'(fs_d), 32'd1);
    checkOutput("rst.line_start",  32'(ls_d), 32'd1);
    #1 reset_n = 1'b1;

    repeat (639) @(posedge vga_clk);
    #1;
    checkOutput("rel.x639",       32'(dx_d), 32'd639);
    checkOutput("rel.blank_x639", 32'(bl_d), 32'd1);
    @(posedge vga_clk);
    #1;
    checkOutput("rel.x640",       32'(dx_d), 32'd640);
    checkOutput("rel.blank_x640", 32'(bl_d), 32'd0);

    repeat (2500) @(posedge vga_clk);

    // Mid-frame reset while the reduced-geometry vs is low.
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(posedge vga_clk);
      #1;
      if ((dy_s == 10'd51) && (dx_s == 10'd10)) found = 1'b1;
    end
    checkOutput("mid.reached_y51", 32'(found), 32'd1);
    checkOutput("mid.vs_low_pre",  32'(vs_s),  32'd0);
    applyStimulus(2, 3, 3);

    // Three full reduced frames: wraps, vs period and default hs placement.
    repeat (14000) @(posedge vga_clk);

    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(200, 2500)) @(posedge vga_clk);
      applyStimulus(offClockEdge(), $urandom_range(2, 5), offClockEdge());
    end

    repeat (2000) @(posedge vga_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
